// File: rtl/fadd_seq_ctrl.sv
// Multi-cycle single-precision float adder sequencer: unpack/order, bit-serial alignment,
// add/sub, iterative normalize, round-to-nearest-even, then hold result until consumed.
module fadd_seq_ctrl #(
  parameter int unsigned SHIFT_CAP = 26
) (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(SHIFT_CAP + 1);

  typedef enum logic [2:0] {
    StIdle, StUnpack, StAlign, StAdd, StNorm, StRound, StHold
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [26:0]     mant_l_q, mant_l_d, mant_s_q, mant_s_d;
  logic [9:0]      exp_q, exp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_q, sign_d, sub_q, sub_d, big_q, big_d, zero_q, zero_d;
  logic [31:0]     result_q, result_d;
  logic            overflow_q, overflow_d;

  // Mantissa layout: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
  function automatic logic [26:0] mant_of(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 27'd0 : {2'b01, x[22:0], 2'b00};
  endfunction

  logic        swap;
  logic [31:0] op_l, op_s;
  logic [7:0]  exp_diff;
  logic        diff_big;
  logic [26:0] mant_s_eff, sum, norm_shift;
  logic        rnd_inc;
  logic [24:0] rnd;
  logic [9:0]  exp_r;
  logic [22:0] frac_r;

  always_comb begin
    swap       = op_b_q[30:0] > op_a_q[30:0];
    op_l       = swap ? op_b_q : op_a_q;
    op_s       = swap ? op_a_q : op_b_q;
    exp_diff   = op_l[30:23] - op_s[30:23];
    diff_big   = {1'b0, exp_diff} > 9'(SHIFT_CAP);
    // Beyond the shift cap the smaller operand only contributes a sticky bit.
    mant_s_eff = big_q ? {26'd0, |mant_s_q} : mant_s_q;
    sum        = sub_q ? (mant_l_q - mant_s_eff) : (mant_l_q + mant_s_eff);
    norm_shift = mant_l_q[26] ? {1'b0, mant_l_q[26:2], mant_l_q[1] | mant_l_q[0]}
                              : {mant_l_q[25:0], 1'b0};
    rnd_inc    = mant_l_q[1] & (mant_l_q[0] | mant_l_q[2]);
    rnd        = {1'b0, mant_l_q[25:2]} + {24'd0, rnd_inc};
    exp_r      = exp_q + {9'd0, rnd[24]};
    frac_r     = rnd[24] ? rnd[23:1] : rnd[22:0];
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    mant_l_d   = mant_l_q;
    mant_s_d   = mant_s_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    big_d      = big_q;
    zero_d     = zero_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b;
          zero_d  = 1'b0;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        mant_l_d = mant_of(op_l);
        mant_s_d = mant_of(op_s);
        exp_d    = {2'b00, op_l[30:23]};
        sign_d   = op_l[31];
        sub_d    = op_l[31] ^ op_s[31];
        big_d    = diff_big;
        cnt_d    = diff_big ? CntW'(SHIFT_CAP) : CntW'(exp_diff);
        state_d  = (cnt_d != '0) ? StAlign : StAdd;
      end
      StAlign: begin
        mant_s_d = {1'b0, mant_s_q[26:2], mant_s_q[1] | mant_s_q[0]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StAdd;
      end
      StAdd: begin
        if (sum == 27'd0) begin
          zero_d  = 1'b1;
          sign_d  = 1'b0;
          state_d = StRound;
        end else begin
          mant_l_d = sum;
          state_d  = (sum[26] || !sum[25]) ? StNorm : StRound;
        end
      end
      StNorm: begin
        if (!mant_l_q[26] && exp_q == 10'd1) begin
          zero_d  = 1'b1;
          state_d = StRound;
        end else begin
          mant_l_d = norm_shift;
          exp_d    = mant_l_q[26] ? exp_q + 10'd1 : exp_q - 10'd1;
          if (norm_shift[26:25] == 2'b01) state_d = StRound;
        end
      end
      StRound: begin
        overflow_d = 1'b0;
        if (zero_q) begin
          result_d = {sign_q, 31'd0};
        end else if (exp_r >= 10'd255) begin
          result_d   = {sign_q, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else begin
          result_d = {sign_q, exp_r[7:0], frac_r};
        end
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      mant_l_q   <= '0;
      mant_s_q   <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      big_q      <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      mant_l_q   <= mant_l_d;
      mant_s_q   <= mant_s_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      big_q      <= big_d;
      zero_q     <= zero_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StHold);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fadd_seq_ctrl.sv
// Self-checking bench for fadd_seq_ctrl: directed cases plus randomized operands checked
// against an arithmetic reference model of the add/align/normalize/round rules.
module tb_fadd_seq_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fadd_seq_ctrl #(.SHIFT_CAP(26)) dut (
    .clk      (clk),
    .res      (res),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: align with sticky, add/sub, normalize loop, RNE round; also predicts latency.
  function automatic void ref_add(input logic [31:0] xa, input logic [31:0] xb,
                                  output logic [31:0] r, output logic ov, output int lat);
    logic [31:0] l, s;
    logic [26:0] ml, ms, m;
    logic        sgn, flush, inc;
    int          el, es, d, cnt, n, e, q;
    if (xb[30:0] > xa[30:0]) begin l = xb; s = xa; end
    else begin l = xa; s = xb; end
    el  = int'(l[30:23]);
    es  = int'(s[30:23]);
    ml  = (el == 0) ? 27'd0 : {2'b01, l[22:0], 2'b00};
    ms  = (es == 0) ? 27'd0 : {2'b01, s[22:0], 2'b00};
    d   = el - es;
    cnt = (d > 26) ? 26 : d;
    if (d > 26) ms = {26'd0, ms != 27'd0};
    else ms = (ms >> d) | {26'd0, (ms & ((27'd1 << d) - 27'd1)) != 27'd0};
    m   = (l[31] == s[31]) ? ml + ms : ml - ms;
    sgn = l[31];
    e   = el;
    n   = 0;
    ov  = 1'b0;
    if (m == 27'd0) begin
      r = 32'd0;
    end else begin
      flush = 1'b0;
      while (m[26] || !m[25]) begin
        n++;
        if (m[26]) begin m = (m >> 1) | (m & 27'd1); e++; end
        else if (e == 1) begin flush = 1'b1; break; end
        else begin m = m << 1; e--; end
      end
      if (flush) begin
        r = {sgn, 31'd0};
      end else begin
        inc = m[1] & (m[0] | m[2]);
        q   = int'(m[25:2]) + int'(inc);
        if (q >= (1 << 24)) begin q = q >> 1; e++; end
        if (e >= 255) begin r = {sgn, 8'hFF, 23'd0}; ov = 1'b1; end
        else r = {sgn, 8'(e), 23'(q)};
      end
    end
    lat = 3 + cnt + n;
  endfunction

  // One transaction; noisy keeps in_valid high with junk while busy, hold stalls out_ready.
  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input int hold, input bit noisy);
    logic [31:0] er;
    logic        eo;
    int          el, lat;
    ref_add(xa, xb, er, eo, el);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = noisy;
    a = $urandom; b = $urandom;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
      a = $urandom; b = $urandom;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_result"}, result, er);
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, result, er);
      check({tag, "_hold_ovf"}, 32'(overflow), 32'(eo));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    res = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    res = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 0, 1'b0);
    check("one_plus_one_const", result, 32'h40000000);
    run_op("onehalf_sum", 32'h3FC00000, 32'h3F400000, 0, 1'b0);
    check("onehalf_sum_const", result, 32'h40100000);
    run_op("cancel", 32'h3F800000, 32'hBF800000, 0, 1'b0);
    check("cancel_const", result, 32'h00000000);
    run_op("tie_even", 32'h3F800000, 32'h33800000, 0, 1'b0);
    check("tie_even_const", result, 32'h3F800000);
    run_op("tie_odd", 32'h3F800001, 32'h33800000, 0, 1'b1);
    check("tie_odd_const", result, 32'h3F800002);
    run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 10, 1'b0);
    check("ovf_const", result, 32'h7F800000);
    run_op("zero_operand", 32'h00000000, 32'h3F800000, 0, 1'b0);
    run_op("cap_26", 32'h3F800000, 32'h32800000, 0, 1'b0);
    run_op("cap_27", 32'hBF800000, 32'h32000000, 0, 1'b0);
    run_op("underflow", 32'h00C00000, 32'h80A00000, 0, 1'b0);

    // Reset in the middle of alignment must abandon the operation.
    a = 32'h3F800000; b = 32'h33800000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", result, 32'd0);
    seen = 0;
    repeat (30) begin tick(); if (out_valid) seen++; end
    check("midrst_no_partial", 32'(seen), 32'd0);
    run_op("after_rst", 32'h3F800000, 32'h3F800000, 0, 1'b0);
    check("after_rst_const", result, 32'h40000000);

    for (int i = 0; i < 40; i++) begin
      int ea, eb;
      logic [31:0] xa, xb;
      ea = int'($urandom_range(1, 254));
      case ($urandom_range(0, 3))
        0: eb = ea + int'($urandom_range(0, 4)) - 2;
        1: eb = int'($urandom_range(1, 254));
        2: begin ea = int'($urandom_range(252, 254)); eb = ea - int'($urandom_range(0, 1)); end
        default: begin ea = int'($urandom_range(1, 3)); eb = int'($urandom_range(1, 3)); end
      endcase
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      xa = {1'($urandom), 8'(ea), 23'($urandom)};
      xb = {1'($urandom), 8'(eb), 23'($urandom)};
      run_op("rand", xa, xb, int'($urandom_range(0, 2)), (i % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
